// File: rtl/sdram_port_arbiter.sv
// Two-master round-robin arbiter for the SDRAM controller Avalon-MM port.
// Define SDRAM_ARB_FIXED_PRIO_EN for fixed M0-over-M1 priority.
module sdram_port_arbiter #(
    parameter int  ADDR_W      = 24,
    parameter int  DATA_W      = 16,
    parameter int  MAX_PENDING = 8,
    localparam int BE_W        = DATA_W / 8
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [ADDR_W-1:0] m0_address,
    input  logic              m0_read,
    input  logic              m0_write,
    input  logic [DATA_W-1:0] m0_writedata,
    input  logic [BE_W-1:0]   m0_byteenable,
    output logic              m0_waitrequest,
    output logic [DATA_W-1:0] m0_readdata,
    output logic              m0_readdatavalid,
    input  logic [ADDR_W-1:0] m1_address,
    input  logic              m1_read,
    input  logic              m1_write,
    input  logic [DATA_W-1:0] m1_writedata,
    input  logic [BE_W-1:0]   m1_byteenable,
    output logic              m1_waitrequest,
    output logic [DATA_W-1:0] m1_readdata,
    output logic              m1_readdatavalid,
    output logic [ADDR_W-1:0] s_address,
    output logic              s_read,
    output logic              s_write,
    output logic [DATA_W-1:0] s_writedata,
    output logic [BE_W-1:0]   s_byteenable,
    input  logic              s_waitrequest,
    input  logic [DATA_W-1:0] s_readdata,
    input  logic              s_readdatavalid,
    output logic              rd_err
);
    localparam int PW = $clog2(MAX_PENDING);

    typedef enum logic [1:0] {
        G_NONE = 2'd0,
        G_M0   = 2'd1,
        G_M1   = 2'd2
    } gnt_t;

    gnt_t gnt, pick, gnt_nxt;
    logic last;
    logic [MAX_PENDING-1:0] tag_mem;
    logic [PW-1:0] wr_ptr, rd_ptr;
    logic [PW:0] count;
    logic req0, req1, sel0, sel1;
    logic g_read, g_write, g_req;
    logic empty, tag_full, head;
    logic accept, push, pop, rearb, other_idle;

    assign req0     = m0_read | m0_write;
    assign req1     = m1_read | m1_write;
    assign sel0     = (gnt == G_M0);
    assign sel1     = (gnt == G_M1);
    assign g_read   = (sel0 & m0_read) | (sel1 & m1_read);
    assign g_write  = (sel0 & m0_write) | (sel1 & m1_write);
    assign g_req    = g_read | g_write;
    assign empty    = (count == '0);
    assign tag_full = (count == (PW+1)'(MAX_PENDING));
    assign head     = tag_mem[rd_ptr];

    assign s_read  = g_read & ~tag_full;
    assign s_write = g_write;

    always_comb begin
        s_address    = m0_address;
        s_writedata  = m0_writedata;
        s_byteenable = m0_byteenable;
        if (sel1) begin
            s_address    = m1_address;
            s_writedata  = m1_writedata;
            s_byteenable = m1_byteenable;
        end
    end

    assign accept = (s_read | s_write) & ~s_waitrequest;
    assign push   = accept & s_read;
    assign pop    = s_readdatavalid & ~empty;

    assign m0_waitrequest = ~sel0 | s_waitrequest | (m0_read & tag_full);
    assign m1_waitrequest = ~sel1 | s_waitrequest | (m1_read & tag_full);

    assign m0_readdata      = s_readdata;
    assign m1_readdata      = s_readdata;
    assign m0_readdatavalid = pop & ~head;
    assign m1_readdatavalid = pop & head;

    // A read held off by a full tag FIFO is not on the bus, so the grant may move.
    assign rearb      = (gnt == G_NONE) | ~g_req | accept | (g_read & tag_full);
    assign other_idle = sel0 ? ~req1 : ~req0;

`ifdef SDRAM_ARB_FIXED_PRIO_EN
    always_comb begin
        pick = G_NONE;
        if (req0)      pick = G_M0;
        else if (req1) pick = G_M1;
    end
`else
    logic last_eff;
    assign last_eff = accept ? sel1 : last;

    always_comb begin
        pick = G_NONE;
        if (last_eff) begin
            if (req0)      pick = G_M0;
            else if (req1) pick = G_M1;
        end else begin
            if (req1)      pick = G_M1;
            else if (req0) pick = G_M0;
        end
    end
`endif

    always_comb begin
        gnt_nxt = gnt;
        if (rearb) gnt_nxt = (accept & other_idle) ? gnt : pick;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            gnt     <= G_NONE;
            last    <= 1'b1;
            tag_mem <= '0;
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count   <= '0;
            rd_err  <= 1'b0;
        end else begin
            gnt <= gnt_nxt;
            if (accept) last <= sel1;
            if (push) begin
                tag_mem[wr_ptr] <= sel1;
                wr_ptr          <= wr_ptr + 1'b1;
            end
            if (pop) rd_ptr <= rd_ptr + 1'b1;
            unique case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
            if (s_readdatavalid & empty) rd_err <= 1'b1;
        end
    end
endmodule
